// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register for the RISC-Bubble core. Decodes the
// incoming opcode/funct into an ALU func_code, resolves EX/MEM and MEM/WB
// forwarding, selects and extends the immediate, and registers all operands
// and control signals consumed by EX and later stages. Flush, an empty slot
// or an illegal instruction load a bubble (all outputs zero); stall holds.
//
// Optional feature: define IDEX_BUBBLE_CNT_EN to build the saturating bubble
// counter. When undefined, bubble_cnt is tied to 0.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid                    decode presents an instruction
//   opcode, funct               instruction [31:26] and [5:0]
//   rs_addr, rt_addr, rd_addr   register fields
//   shamt_in, imm               shift amount and immediate fields
//   rs_data, rt_data            register-file read data
//   exmem_wr_en/rd/data         EX/MEM forward source (higher priority)
//   memwb_wr_en/rd/data         MEM/WB forward source
//   stall, flush                hold the stage / load a bubble
//   arg1, arg2, func_code, shamt  ALU operands and operation
//   store_data                  forwarded rt value
//   dest_reg, reg_write         write-back register and enable
//   mem_read, mem_write, branch memory and branch controls
//   valid_out                   stage holds a real instruction
//   illegal                     one-cycle pulse on an illegal instruction
//   bubble_cnt                  saturating count of inserted bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    input  logic [4:0]       rd_addr,
    input  logic [4:0]       shamt_in,
    input  logic [15:0]      imm,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             exmem_wr_en,
    input  logic [4:0]       exmem_rd,
    input  logic [31:0]      exmem_data,
    input  logic             memwb_wr_en,
    input  logic [4:0]       memwb_rd,
    input  logic [31:0]      memwb_data,
    input  logic             stall,
    input  logic             flush,
    output logic [31:0]      arg1,
    output logic [31:0]      arg2,
    output logic [2:0]       func_code,
    output logic [4:0]       shamt,
    output logic [31:0]      store_data,
    output logic [4:0]       dest_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic             valid_out,
    output logic             illegal,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [2:0] {
        FC_ADD = 3'd0, FC_SUB = 3'd1, FC_AND = 3'd2, FC_OR  = 3'd3,
        FC_SLL = 3'd4, FC_SRL = 3'd5, FC_SLT = 3'd6, FC_BR  = 3'd7
    } func_e;

    typedef enum logic [1:0] {A2_RT, A2_ZERO, A2_SEXT, A2_ZEXT} arg2_sel_e;
    typedef enum logic [1:0] {DST_RD, DST_RT, DST_NONE} dest_sel_e;

    // Decode results
    logic      legal, is_shift, is_lw, is_sw, is_br;
    func_e     fc;
    arg2_sel_e a2_sel;
    dest_sel_e d_sel;

    // Forwarded operands and next-state values
    logic [31:0] rs_fwd, rt_fwd, nxt_arg1, nxt_arg2;
    logic [4:0]  nxt_dest;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        legal    = 1'b1;
        fc       = FC_ADD;
        a2_sel   = A2_RT;
        d_sel    = DST_RT;
        is_shift = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_br    = 1'b0;
        unique case (opcode)
            6'h00: begin
                d_sel = DST_RD;
                unique case (funct)
                    6'h20, 6'h21: fc = FC_ADD;
                    6'h22, 6'h23: fc = FC_SUB;
                    6'h24:        fc = FC_AND;
                    6'h25:        fc = FC_OR;
                    6'h00:        begin fc = FC_SLL; is_shift = 1'b1; a2_sel = A2_ZERO; end
                    6'h02:        begin fc = FC_SRL; is_shift = 1'b1; a2_sel = A2_ZERO; end
                    6'h2A:        fc = FC_SLT;
                    default:      legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: a2_sel = A2_SEXT;
            6'h23:        begin a2_sel = A2_SEXT; is_lw = 1'b1; end
            6'h2B:        begin a2_sel = A2_SEXT; is_sw = 1'b1; d_sel = DST_NONE; end
            6'h0C:        begin a2_sel = A2_ZEXT; fc = FC_AND; end
            6'h0D:        begin a2_sel = A2_ZEXT; fc = FC_OR; end
            6'h0A:        begin a2_sel = A2_SEXT; fc = FC_SLT; end
            6'h04, 6'h05: begin fc = FC_BR; is_br = 1'b1; d_sel = DST_NONE; end
            default:      legal = 1'b0;
        endcase
    end

    // Forwarding: r0 is never forwarded; EX/MEM wins over MEM/WB.
    always_comb begin
        rs_fwd = rs_data;
        if (rs_addr != 5'd0) begin
            if (exmem_wr_en && exmem_rd == rs_addr)      rs_fwd = exmem_data;
            else if (memwb_wr_en && memwb_rd == rs_addr) rs_fwd = memwb_data;
        end
        rt_fwd = rt_data;
        if (rt_addr != 5'd0) begin
            if (exmem_wr_en && exmem_rd == rt_addr)      rt_fwd = exmem_data;
            else if (memwb_wr_en && memwb_rd == rt_addr) rt_fwd = memwb_data;
        end
    end

    // Operand and destination selection
    always_comb begin
        nxt_arg1 = is_shift ? rt_fwd : rs_fwd;
        unique case (a2_sel)
            A2_ZERO: nxt_arg2 = 32'd0;
            A2_SEXT: nxt_arg2 = {{16{imm[15]}}, imm};
            A2_ZEXT: nxt_arg2 = {16'd0, imm};
            default: nxt_arg2 = rt_fwd;
        endcase
        unique case (d_sel)
            DST_RD:  nxt_dest = rd_addr;
            DST_RT:  nxt_dest = rt_addr;
            default: nxt_dest = 5'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {arg1, arg2, func_code, shamt, store_data, dest_reg} <= '0;
            {reg_write, mem_read, mem_write, branch, valid_out, illegal} <= '0;
        end else if (flush || (!stall && (!in_valid || !legal))) begin
            // Bubble; the only flavour that raises illegal is a real decode
            // failure on an accepted, unflushed slot.
            {arg1, arg2, func_code, shamt, store_data, dest_reg} <= '0;
            {reg_write, mem_read, mem_write, branch, valid_out} <= '0;
            illegal <= !flush && in_valid && !legal;
        end else if (stall) begin
            illegal <= 1'b0;
        end else begin
            arg1       <= nxt_arg1;
            arg2       <= nxt_arg2;
            func_code  <= fc;
            shamt      <= is_shift ? shamt_in : 5'd0;
            store_data <= rt_fwd;
            dest_reg   <= nxt_dest;
            reg_write  <= (nxt_dest != 5'd0);
            mem_read   <= is_lw;
            mem_write  <= is_sw;
            branch     <= is_br;
            valid_out  <= 1'b1;
            illegal    <= 1'b0;
        end
    end

`ifdef IDEX_BUBBLE_CNT_EN
    logic load_bubble;
    assign load_bubble = flush || (!stall && (!in_valid || !legal));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bubble_cnt <= '0;
        else if (load_bubble && bubble_cnt != {CNT_W{1'b1}})
            bubble_cnt <= bubble_cnt + 1'b1;
    end
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed scoreboard bench for id_ex_stage. The driver applies one vector per
// cycle on the falling edge and pushes the hand-computed expected register
// contents; the monitor pops one entry 1 ns after each rising edge and compares.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [31:0]      a1;
        logic [31:0]      a2;
        logic [2:0]       fc;
        logic [4:0]       sh;
        logic [31:0]      sd;
        logic [4:0]       dst;
        logic             rw;
        logic             mr;
        logic             mw;
        logic             br;
        logic             vld;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [5:0]       opcode, funct;
    logic [4:0]       rs_addr, rt_addr, rd_addr, shamt_in;
    logic [15:0]      imm;
    logic [31:0]      rs_data, rt_data;
    logic             exmem_wr_en, memwb_wr_en;
    logic [4:0]       exmem_rd, memwb_rd;
    logic [31:0]      exmem_data, memwb_data;
    logic             stall, flush;
    logic [31:0]      arg1, arg2, store_data;
    logic [2:0]       func_code;
    logic [4:0]       shamt, dest_reg;
    logic             reg_write, mem_read, mem_write, branch, valid_out, illegal;
    logic [CNT_W-1:0] bubble_cnt;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .opcode(opcode), .funct(funct),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .shamt_in(shamt_in), .imm(imm), .rs_data(rs_data), .rt_data(rt_data),
        .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .stall(stall), .flush(flush),
        .arg1(arg1), .arg2(arg2), .func_code(func_code), .shamt(shamt),
        .store_data(store_data), .dest_reg(dest_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
        .valid_out(valid_out), .illegal(illegal), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    exp_t   sb[$];
    string  sb_name[$];
    exp_t   last;
    logic [CNT_W-1:0] cnt_model = '0;

    function automatic exp_t actual();
        exp_t a;
        a = '{a1: arg1, a2: arg2, fc: func_code, sh: shamt, sd: store_data,
              dst: dest_reg, rw: reg_write, mr: mem_read, mw: mem_write,
              br: branch, vld: valid_out, ill: illegal, cnt: bubble_cnt};
        return a;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got a1=%h a2=%h fc=%0d sh=%0d sd=%h dst=%0d rw%b mr%b mw%b br%b v%b il%b cnt=%0d | want a1=%h a2=%h fc=%0d sh=%0d sd=%h dst=%0d rw%b mr%b mw%b br%b v%b il%b cnt=%0d",
                     name, got.a1, got.a2, got.fc, got.sh, got.sd, got.dst, got.rw, got.mr,
                     got.mw, got.br, got.vld, got.ill, got.cnt,
                     want.a1, want.a2, want.fc, want.sh, want.sd, want.dst, want.rw, want.mr,
                     want.mw, want.br, want.vld, want.ill, want.cnt);
        end
    endtask

    // Expected value of the counter as seen at the outputs.
    function automatic logic [CNT_W-1:0] cnt_seen();
`ifdef IDEX_BUBBLE_CNT_EN
        return cnt_model;
`else
        return '0;
`endif
    endfunction

    // Expected loaded instruction (valid_out = 1, illegal = 0).
    function automatic exp_t mk(input logic [31:0] a1, input logic [31:0] a2,
                                input logic [2:0] fc, input logic [4:0] sh,
                                input logic [31:0] sd, input logic [4:0] dst,
                                input logic rw, input logic mr, input logic mw,
                                input logic br);
        exp_t e;
        e = '{a1: a1, a2: a2, fc: fc, sh: sh, sd: sd, dst: dst, rw: rw, mr: mr,
              mw: mw, br: br, vld: 1'b1, ill: 1'b0, cnt: cnt_seen()};
        return e;
    endfunction

    // Expected bubble; advances the saturating counter model.
    function automatic exp_t bub(input logic ill);
        exp_t e;
        if (cnt_model != {CNT_W{1'b1}}) cnt_model = cnt_model + 1'b1;
        e = '0;
        e.ill = ill;
        e.cnt = cnt_seen();
        return e;
    endfunction

    // Expected stall cycle: previous contents held, illegal cleared.
    function automatic exp_t hold();
        exp_t e;
        e = last;
        e.ill = 1'b0;
        return e;
    endfunction

    task automatic push(input string name, input exp_t e);
        sb.push_back(e);
        sb_name.push_back(name);
        last = e;
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh,
                          input logic [15:0] im, input logic [31:0] rsd,
                          input logic [31:0] rtd);
        in_valid = 1'b1; opcode = op; funct = fn;
        rs_addr = rs; rt_addr = rt; rd_addr = rd; shamt_in = sh; imm = im;
        rs_data = rsd; rt_data = rtd;
        exmem_wr_en = 1'b0; exmem_rd = 5'd0; exmem_data = 32'd0;
        memwb_wr_en = 1'b0; memwb_rd = 5'd0; memwb_data = 32'd0;
        stall = 1'b0; flush = 1'b0;
    endtask

    // Monitor: one output word per rising edge while expectations are pending.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) check(sb_name.pop_front(), actual(), sb.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        set_in(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'd0, 32'd0);
        in_valid = 1'b0;
        #1;
        check("reset_init", actual(), exp_t'(0));

        // ---------------- decode and operand selection ----------------
        @(negedge clk); reset = 1'b0;
        set_in(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7);
        push("add", mk(32'd5, 32'd7, 3'd0, 5'd0, 32'd7, 5'd3, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h00, 6'h23, 5'd1, 5'd2, 5'd4, 5'd0, 16'h0, 32'd10, 32'd3);
        push("subu", mk(32'd10, 32'd3, 3'd1, 5'd0, 32'd3, 5'd4, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h00, 6'h24, 5'd1, 5'd2, 5'd5, 5'd0, 16'h0, 32'hF0F0, 32'hFF00);
        push("and", mk(32'hF0F0, 32'hFF00, 3'd2, 5'd0, 32'hFF00, 5'd5, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h00, 6'h25, 5'd1, 5'd2, 5'd6, 5'd0, 16'h0, 32'd1, 32'd2);
        push("or", mk(32'd1, 32'd2, 3'd3, 5'd0, 32'd2, 5'd6, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h00, 6'h2A, 5'd1, 5'd2, 5'd7, 5'd0, 16'h0, 32'd3, 32'd4);
        push("slt", mk(32'd3, 32'd4, 3'd6, 5'd0, 32'd4, 5'd7, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h00, 6'h00, 5'd1, 5'd2, 5'd8, 5'd4, 16'h0, 32'h99, 32'd7);
        push("sll", mk(32'd7, 32'd0, 3'd4, 5'd4, 32'd7, 5'd8, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h00, 6'h02, 5'd1, 5'd2, 5'd9, 5'd31, 16'h0, 32'd1, 32'h80000000);
        push("srl", mk(32'h80000000, 32'd0, 3'd5, 5'd31, 32'h80000000, 5'd9, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h08, 6'h00, 5'd1, 5'd5, 5'd0, 5'd0, 16'hFFFF, 32'd1, 32'd9);
        push("addi_sext", mk(32'd1, 32'hFFFFFFFF, 3'd0, 5'd0, 32'd9, 5'd5, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h0C, 6'h00, 5'd1, 5'd6, 5'd0, 5'd0, 16'h8001, 32'd3, 32'd0);
        push("andi_zext", mk(32'd3, 32'h00008001, 3'd2, 5'd0, 32'd0, 5'd6, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h0D, 6'h00, 5'd1, 5'd7, 5'd0, 5'd0, 16'hF000, 32'd1, 32'd2);
        push("ori_zext", mk(32'd1, 32'h0000F000, 3'd3, 5'd0, 32'd2, 5'd7, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h0A, 6'h00, 5'd1, 5'd10, 5'd0, 5'd0, 16'h8000, 32'd4, 32'd0);
        push("slti_sext", mk(32'd4, 32'hFFFF8000, 3'd6, 5'd0, 32'd0, 5'd10, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 5'd0, 16'h0010, 32'd100, 32'd0);
        push("lw", mk(32'd100, 32'h10, 3'd0, 5'd0, 32'd0, 5'd8, 1, 1, 0, 0));
        @(negedge clk); set_in(6'h2B, 6'h00, 5'd1, 5'd9, 5'd0, 5'd0, 16'hFFFC, 32'h200, 32'h55);
        push("sw", mk(32'h200, 32'hFFFFFFFC, 3'd0, 5'd0, 32'h55, 5'd0, 0, 0, 1, 0));
        @(negedge clk); set_in(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0004, 32'd3, 32'd3);
        push("beq", mk(32'd3, 32'd3, 3'd7, 5'd0, 32'd3, 5'd0, 0, 0, 0, 1));
        @(negedge clk); set_in(6'h05, 6'h00, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0004, 32'd1, 32'd2);
        push("bne", mk(32'd1, 32'd2, 3'd7, 5'd0, 32'd2, 5'd0, 0, 0, 0, 1));
        @(negedge clk); set_in(6'h00, 6'h21, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 32'd5, 32'd7);
        push("addu_rd0", mk(32'd5, 32'd7, 3'd0, 5'd0, 32'd7, 5'd0, 0, 0, 0, 0));

        // ---------------- forwarding ----------------
        @(negedge clk); set_in(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7);
        exmem_wr_en = 1'b1; exmem_rd = 5'd1; exmem_data = 32'hA;
        memwb_wr_en = 1'b1; memwb_rd = 5'd1; memwb_data = 32'hB;
        push("fwd_exmem_prio", mk(32'hA, 32'd7, 3'd0, 5'd0, 32'd7, 5'd3, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h00, 6'h20, 5'd0, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7);
        exmem_wr_en = 1'b1; exmem_rd = 5'd1; exmem_data = 32'hA;
        memwb_wr_en = 1'b1; memwb_rd = 5'd1; memwb_data = 32'hB;
        push("fwd_rs0", mk(32'd5, 32'd7, 3'd0, 5'd0, 32'd7, 5'd3, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7);
        exmem_wr_en = 1'b0; exmem_rd = 5'd1; exmem_data = 32'hA;
        memwb_wr_en = 1'b1; memwb_rd = 5'd2; memwb_data = 32'hB;
        push("fwd_memwb_rt", mk(32'd5, 32'hB, 3'd0, 5'd0, 32'hB, 5'd3, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h2B, 6'h00, 5'd1, 5'd9, 5'd0, 5'd0, 16'h0004, 32'h300, 32'h55);
        exmem_wr_en = 1'b1; exmem_rd = 5'd9; exmem_data = 32'h77;
        push("fwd_sw_store", mk(32'h300, 32'd4, 3'd0, 5'd0, 32'h77, 5'd0, 0, 0, 1, 0));
        @(negedge clk); set_in(6'h00, 6'h20, 5'd0, 5'd0, 5'd3, 5'd0, 16'h0, 32'd5, 32'd6);
        exmem_wr_en = 1'b1; exmem_rd = 5'd0; exmem_data = 32'hA;
        memwb_wr_en = 1'b1; memwb_rd = 5'd0; memwb_data = 32'hB;
        push("fwd_r0_never", mk(32'd5, 32'd6, 3'd0, 5'd0, 32'd6, 5'd3, 1, 0, 0, 0));

        // ---------------- bubbles, stall, flush, illegal ----------------
        @(negedge clk); set_in(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7);
        in_valid = 1'b0;
        push("empty_slot", bub(1'b0));
        @(negedge clk); set_in(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7);
        push("add_pre_stall", mk(32'd5, 32'd7, 3'd0, 5'd0, 32'd7, 5'd3, 1, 0, 0, 0));
        @(negedge clk); stall = 1'b1; rs_data = 32'd99;
        push("stall_1", hold());
        @(negedge clk); rt_data = 32'd98;
        push("stall_2", hold());
        @(negedge clk); flush = 1'b1;
        push("stall_flush", bub(1'b0));
        @(negedge clk); set_in(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7);
        push("illegal_op", bub(1'b1));
        @(negedge clk); stall = 1'b1;
        push("illegal_drop_stall", hold());
        @(negedge clk); set_in(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7);
        push("illegal_funct", bub(1'b1));
        @(negedge clk); set_in(6'h00, 6'h22, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd9, 32'd4);
        push("sub_after_illegal", mk(32'd9, 32'd4, 3'd1, 5'd0, 32'd4, 5'd3, 1, 0, 0, 0));
        @(negedge clk); set_in(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7);
        flush = 1'b1;
        push("flush_valid", bub(1'b0));
        @(negedge clk); set_in(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'd5, 32'd7);
        push("add_pre_reset", mk(32'd5, 32'd7, 3'd0, 5'd0, 32'd7, 5'd3, 1, 0, 0, 0));

        // ---------------- asynchronous reset mid-stream ----------------
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        cnt_model = '0;
        check("reset_async", actual(), exp_t'(0));
        @(negedge clk); reset = 1'b0;
        set_in(6'h00, 6'h22, 5'd1, 5'd2, 5'd4, 5'd0, 16'h0, 32'd8, 32'd2);
        push("sub_after_reset", mk(32'd8, 32'd2, 3'd1, 5'd0, 32'd2, 5'd4, 1, 0, 0, 0));
        @(negedge clk); in_valid = 1'b0;
        push("bubble_after_reset", bub(1'b0));

        // Drain the scoreboard with a bounded wait.
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected outputs never observed, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the RISC-Bubble core. Each cycle it takes one decoded instruction and its register-file operands, and produces the ALU `func_code`. It resolves EX/MEM and MEM/WB forwarding, selects and extends the immediate, and registers everything that the ALU and later stages consume. Stall holds the stage; flush, an empty slot, or an illegal instruction inserts a bubble.

## Interface
- `CNT_W`, 16, width of the bubble counter

- `clk` in 1, rising-edge clock
- `reset` in 1, asynchronous, active-high
- `in_valid` in 1, decode presents an instruction
- `opcode` in 6, instruction [31:26]
- `funct` in 6, instruction [5:0]
- `rs_addr`, `rt_addr`, `rd_addr` in 5 each, register fields
- `shamt_in` in 5, shift amount field
- `imm` in 16, immediate field
- `rs_data`, `rt_data` in 32 each, register-file read data
- `exmem_wr_en` in 1, `exmem_rd` in 5, `exmem_data` in 32: EX/MEM forward source
- `memwb_wr_en` in 1, `memwb_rd` in 5, `memwb_data` in 32: MEM/WB forward source
- `stall` in 1, hold the stage
- `flush` in 1, replace the stage contents with a bubble
- `arg1`, `arg2` out 32, ALU operands
- `func_code` out 3, ALU operation
- `shamt` out 5, ALU shift amount
- `store_data` out 32, forwarded rt value for `sw`
- `dest_reg` out 5, write-back register
- `reg_write`, `mem_read`, `mem_write`, `branch`, `valid_out` out 1 each
- `illegal` out 1, one-cycle pulse on an illegal instruction
- `bubble_cnt` out CNT_W, count of inserted bubbles

## Operation
**Decode to `func_code`:**
- R-type (`opcode` 0x00), by `funct`:
  - add 0x20 and addu 0x21 → 0
  - sub 0x22 and subu 0x23 → 1
  - and 0x24 → 2
  - or 0x25 → 3
  - sll 0x00 → 4
  - srl 0x02 → 5
  - slt 0x2A → 6
- I-type, by `opcode`:
  - addi 0x08, addiu 0x09, lw 0x23, sw 0x2B → 0
  - andi 0x0C → 2
  - ori 0x0D → 3
  - slti 0x0A → 6
  - beq 0x04 and bne 0x05 → 7
- Any other opcode/funct pair is illegal.

**Operand selection** (`fwd(r, d)` is defined under Forwarding below):
- R-type arithmetic/logic: `arg1` = fwd(rs, `rs_data`), `arg2` = fwd(rt, `rt_data`).
- sll/srl: `arg1` = fwd(rt, `rt_data`), `arg2` = 0, `shamt` = `shamt_in`. All other instructions register `shamt` = 0.
- I-type: `arg1` = fwd(rs, `rs_data`), `arg2` = extended `imm`.
  - Sign-extend for addi, addiu, slti, lw, sw.
  - Zero-extend for andi and ori.
  - beq/bne: `arg2` = fwd(rt, `rt_data`).

**Forwarding**, `fwd(r, d)`:
- If `r` == 0, use `d`.
- Else if `exmem_wr_en` and `exmem_rd` == `r`, use `exmem_data`.
- Else if `memwb_wr_en` and `memwb_rd` == `r`, use `memwb_data`.
- Else use `d`.
- EX/MEM takes priority over MEM/WB.

**Control outputs:**
- `dest_reg`: `rd_addr` for R-type, `rt_addr` for I-type arithmetic/logic and lw, 0 for sw/beq/bne.
- `reg_write` = 1 only when `dest_reg` ≠ 0.
- `mem_read` = lw.
- `mem_write` = sw; `store_data` = fwd(rt, `rt_data`).
- `branch` = beq or bne.

**Bubble:** all outputs 0 (`func_code` 0, so the ALU computes 0 + 0), including `valid_out` = 0.

**Per-cycle priority:**
1. `flush`: load a bubble.
2. `stall`: hold every output unchanged; `illegal` drops to 0.
3. `in_valid` = 0: load a bubble.
4. Illegal instruction: load a bubble and set `illegal` = 1 for one cycle.
5. Otherwise load the decoded instruction with `valid_out` = 1.

**`bubble_cnt`:** increments by 1 on each cycle that loads a bubble (cases 1, 3, 4). It saturates at all-ones and does not change on stall cycles.

## Timing
- All outputs are registered. Inputs sampled at edge N appear after edge N; the ALU result follows one edge later.
- Forwarding is combinational on the current-cycle inputs and is captured at the same edge. Values held during a stall are not re-forwarded. The hazard unit guarantees that held operands remain correct.
- `reset` asynchronously forces every output to 0, including `bubble_cnt` and `illegal`, at any point in operation. The first load happens at the first rising edge after deassertion.
- `flush` and `stall` asserted in the same cycle: a bubble is loaded and the counter increments.
- No valid/ready handshake. `stall` is the sole backpressure, and upstream must hold its inputs while `stall` is asserted.

## Configuration
- `IDEX_BUBBLE_CNT_EN` defined: the saturating `bubble_cnt` register is built as described.
- `IDEX_BUBBLE_CNT_EN` undefined: no counter logic is built; `bubble_cnt` is a constant 0 and the port remains present.

## Test plan
- Reset pulsed mid-stream with valid data loaded → all outputs read 0 asynchronously, before the next edge; `bubble_cnt` = 0.
- `add r3,r1,r2`, `rs_data` = 5, `rt_data` = 7, no forwards → after one edge: `arg1` = 5, `arg2` = 7, `func_code` = 0, `dest_reg` = 3, `reg_write` = 1, `valid_out` = 1.
- addi with `imm` = 0xFFFF → `arg2` = 0xFFFFFFFF; andi with `imm` = 0x8001 → `arg2` = 0x00008001, `func_code` = 2.
- rs = 1 with EX/MEM (rd 1, data 0xA) and MEM/WB (rd 1, data 0xB) both writing → `arg1` = 0xA. Same instruction with rs = 0 → `arg1` = `rs_data`.
- Valid add loaded, `stall` for 2 cycles → outputs unchanged and counter unchanged. Then `stall` and `flush` together → bubble, `bubble_cnt` +1 (counter check requires `IDEX_BUBBLE_CNT_EN`).
- opcode 0x3F → bubble with `valid_out` = 0, `illegal` = 1 for exactly one cycle, `bubble_cnt` +1 (counter check requires `IDEX_BUBBLE_CNT_EN`).
